// File: rtl/vga_pkg.sv
// Shared timing defaults, derived 640x480@60 constants and colour types for
// the framebuffer scanout path.
package vga_pkg;

  // Default 640x480@60 timing, in pixels and lines
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_RD_LAT   = 1;

  // Derived totals and sync windows (inclusive bounds) at the defaults
  localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
  localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

  // Counter width shared by hcount/vcount and the framebuffer address ports
  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef logic [23:0] rgb_t;
  localparam rgb_t DEF_FG_RGB = 24'hFFFFFF;
  localparam rgb_t DEF_BG_RGB = 24'h000000;

endpackage

// File: rtl/vga_timing.sv
// Pixel-clock divider and horizontal/vertical raster counters. Everything
// here is decoded from the counters current in a given clk; the scanout
// stage registers it one pixel later.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick,
  output logic o_rd_slot,
  output logic o_pclk,
  output cnt_t o_hcount,
  output cnt_t o_vcount,
  output logic o_active,
  output logic o_hs_raw,
  output logic o_vs_raw,
  output logic o_frame_start
);

  localparam int DIV_W = $clog2(CLK_DIV);
  typedef logic [DIV_W-1:0] div_t;

  localparam div_t DIV_LAST = div_t'(CLK_DIV - 1);
  localparam div_t DIV_HALF = div_t'(CLK_DIV / 2);
  localparam cnt_t H_LAST   = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_VIS    = cnt_t'(H_ACTIVE);
  localparam cnt_t V_VIS    = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_FIRST = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_LAST  = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_LAST  = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  div_t r_div;
  div_t w_div_next;
  cnt_t r_hcount;
  cnt_t r_vcount;
  logic r_pclk;
  logic w_tick;
  logic w_line_end;
  logic w_frame_end;

  assign w_tick      = (r_div == DIV_LAST);
  assign w_div_next  = w_tick ? '0 : r_div + 1'b1;
  assign w_line_end  = w_tick && (r_hcount == H_LAST);
  assign w_frame_end = w_line_end && (r_vcount == V_LAST);

  // Divider and raster counters; the pixel clock is registered from the
  // next divider value so it tracks div without a combinational glitch path
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge
    // values; blocking here would make counter order matter.
    if (reset) begin
      r_div    <= '0;
      r_hcount <= '0;
      r_vcount <= '0;
      r_pclk   <= 1'b0;
    end else begin
      r_div  <= w_div_next;
      r_pclk <= (w_div_next >= DIV_HALF);
      if (w_tick) begin
        if (w_line_end) begin
          r_hcount <= '0;
          r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
        end else begin
          r_hcount <= r_hcount + 1'b1;
        end
      end
    end
  end

  assign o_tick        = w_tick;
  assign o_rd_slot     = (r_div == '0);
  assign o_pclk        = r_pclk;
  assign o_hcount      = r_hcount;
  assign o_vcount      = r_vcount;
  assign o_active      = (r_hcount < H_VIS) && (r_vcount < V_VIS);
  assign o_hs_raw      = !((r_hcount >= HS_FIRST) && (r_hcount <= HS_LAST));
  assign o_vs_raw      = !((r_vcount >= VS_FIRST) && (r_vcount <= VS_LAST));
  assign o_frame_start = w_frame_end;

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer read side: one read per visible pixel at div == 0, colour bit
// sampled on that pixel's tick, and sync/blank/RGB registered together so the
// DAC pins lag the counters by exactly one pixel with no relative skew.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter int   CLK_DIV  = DEF_CLK_DIV,
  parameter int   RD_LAT   = DEF_RD_LAT,
  parameter rgb_t FG_RGB   = DEF_FG_RGB,
  parameter rgb_t BG_RGB   = DEF_BG_RGB
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] fb_x,
  output logic [10:0] fb_y,
  output logic        fb_rd_en,
  input  logic        fb_data,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        vga_clk,
  output logic        frame_start
);

  // The colour bit must land before the tick that samples it
  if (CLK_DIV < 2 || RD_LAT < 1 || RD_LAT > CLK_DIV - 1) begin : g_bad_params
    $error("vga_scanout: need CLK_DIV >= 2 and 1 <= RD_LAT <= CLK_DIV-1");
  end

  logic w_tick;
  logic w_rd_slot;
  logic w_pclk;
  cnt_t w_hcount;
  cnt_t w_vcount;
  logic w_active;
  logic w_hs_raw;
  logic w_vs_raw;
  logic w_frame_start;

  logic r_hs;
  logic r_vs;
  logic r_blank_n;
  rgb_t r_rgb;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .clk           (clk),
    .reset         (reset),
    .o_tick        (w_tick),
    .o_rd_slot     (w_rd_slot),
    .o_pclk        (w_pclk),
    .o_hcount      (w_hcount),
    .o_vcount      (w_vcount),
    .o_active      (w_active),
    .o_hs_raw      (w_hs_raw),
    .o_vs_raw      (w_vs_raw),
    .o_frame_start (w_frame_start)
  );

  assign fb_x        = w_hcount;
  assign fb_y        = w_vcount;
  assign fb_rd_en    = w_rd_slot && w_active && !reset;
  assign frame_start = w_frame_start;
  assign vga_clk     = w_pclk;
  assign vga_sync_n  = 1'b0;

  // Output stage: capture sync, blank and mapped colour for the current
  // pixel on its tick, which is also when the read data is valid
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_rgb     <= '0;
    end else if (w_tick) begin
      r_hs      <= w_hs_raw;
      r_vs      <= w_vs_raw;
      r_blank_n <= w_active;
      r_rgb     <= !w_active ? '0 : (fb_data ? FG_RGB : BG_RGB);
    end
  end

  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank_n = r_blank_n;
  assign vga_r       = r_rgb[23:16];
  assign vga_g       = r_rgb[15:8];
  assign vga_b       = r_rgb[7:0];

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shrunken raster (15x10 totals) so full
// frames fit in a few hundred clks. Expected outputs come from arithmetic on
// the clk index since reset release, not from the DUT's own counters.
module tb_vga_scanout;

  localparam int HA  = 8;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HBP = 2;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 1;
  localparam int CD  = 2;
  localparam int RL  = 1;
  localparam int HT  = HA + HFP + HSW + HBP;   // 15
  localparam int VT  = VA + VFP + VSW + VBP;   // 10
  localparam int FRAME = CD * HT * VT;         // 300 clks
  localparam logic [23:0] FG = 24'h12AB34;
  localparam logic [23:0] BG = 24'h5600C7;

  typedef struct packed {
    logic        rd_en;
    logic        frame_start;
    logic        vclk;
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic [23:0] rgb;
    logic [10:0] x;
    logic [10:0] y;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] fb_x, fb_y;
  logic        fb_rd_en;
  logic        fb_data = 1'b0;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start;

  int checks   = 0;
  int failures = 0;
  int pat_mode = 0;

  vga_scanout #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .CLK_DIV  (CD), .RD_LAT (RL), .FG_RGB (FG), .BG_RGB (BG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fb_x        (fb_x),
    .fb_y        (fb_y),
    .fb_rd_en    (fb_rd_en),
    .fb_data     (fb_data),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .vga_sync_n  (vga_sync_n),
    .vga_clk     (vga_clk),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic pat(input logic [10:0] h, input logic [10:0] v);
    return (pat_mode == 0) ? 1'b1 : (h[0] ^ v[0]);
  endfunction

  // Framebuffer with RD_LAT = 1; between reads the bit is noise so any
  // sampling outside the read slot shows up as a colour error
  always @(posedge clk) begin
    if (fb_rd_en) fb_data <= pat(fb_x, fb_y);
    else          fb_data <= 1'($urandom);
  end

  function automatic obs_t sample();
    obs_t o;
    o.rd_en       = fb_rd_en;
    o.frame_start = frame_start;
    o.vclk        = vga_clk;
    o.hs          = vga_hs;
    o.vs          = vga_vs;
    o.blank_n     = vga_blank_n;
    o.rgb         = {vga_r, vga_g, vga_b};
    o.x           = fb_x;
    o.y           = fb_y;
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  // Expected pins during clk n after release (n = 0 is the first div == 0 clk)
  function automatic obs_t model(input int n);
    obs_t o;
    int dv, p, h, v, q, hq, vq;
    dv = n % CD;
    p  = n / CD;
    h  = p % HT;
    v  = (p / HT) % VT;
    o.rd_en       = (dv == 0) && (h < HA) && (v < VA);
    o.frame_start = (dv == CD - 1) && (h == HT - 1) && (v == VT - 1);
    o.vclk        = (dv >= CD / 2);
    o.x           = 11'(h);
    o.y           = 11'(v);
    if (p == 0) begin
      o.hs = 1'b1; o.vs = 1'b1; o.blank_n = 1'b0; o.rgb = '0;
    end else begin
      q  = p - 1;
      hq = q % HT;
      vq = (q / HT) % VT;
      o.hs      = !((hq >= HA + HFP) && (hq < HA + HFP + HSW));
      o.vs      = !((vq >= VA + VFP) && (vq < VA + VFP + VSW));
      o.blank_n = (hq < HA) && (vq < VA);
      o.rgb     = o.blank_n ? (pat(11'(hq), 11'(vq)) ? FG : BG) : 24'h0;
    end
    return o;
  endfunction

  // Leaves the bench at a negedge with reset still high
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Releases reset and compares every clk against the model
  task automatic run_sb(input int n_cycles, input string tag,
                        output int rd_cnt, output int fs_first, output int fs_second);
    obs_t act, exp;
    reset = 1'b0;
    rd_cnt = 0; fs_first = -1; fs_second = -1;
    for (int n = 0; n < n_cycles; n++) begin
      #1;
      act = sample();
      exp = model(n);
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL %s clk=%0d got=%h expected=%h", tag, n, act, exp);
      end
      if (n < FRAME && act.rd_en) rd_cnt++;
      if (act.frame_start) begin
        if (fs_first < 0) fs_first = n;
        else if (fs_second < 0) fs_second = n;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    obs_t act;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    act = sample();
    checks++;
    if (act !== reset_obs()) begin
      failures++;
      $display("FAIL reset_values got=%h expected=%h", act, reset_obs());
    end
    checks++;
    if (vga_sync_n !== 1'b0) begin
      failures++;
      $display("FAIL reset_sync_n got=%b expected=0", vga_sync_n);
    end
  endtask

  task automatic test_first_read();
    pat_mode = 0;
    apply_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({fb_rd_en, fb_x, fb_y} !== {1'b1, 11'd0, 11'd0}) begin
      failures++;
      $display("FAIL first_read got rd=%b x=%0d y=%0d expected rd=1 x=0 y=0", fb_rd_en, fb_x, fb_y);
    end
    @(negedge clk); #1;
    checks++;
    if ({vga_clk, fb_rd_en, vga_r, vga_g, vga_b} !== {1'b1, 1'b0, 24'h0}) begin
      failures++;
      $display("FAIL first_read_mid got vclk=%b rd=%b rgb=%h expected vclk=1 rd=0 rgb=000000",
               vga_clk, fb_rd_en, {vga_r, vga_g, vga_b});
    end
    @(negedge clk); #1;
    checks++;
    if ({vga_r, vga_g, vga_b, vga_blank_n} !== {FG, 1'b1}) begin
      failures++;
      $display("FAIL first_pixel got rgb=%h blank_n=%b expected rgb=%h blank_n=1",
               {vga_r, vga_g, vga_b}, vga_blank_n, FG);
    end
  endtask

  task automatic test_full_frame();
    int rd, f1, f2;
    pat_mode = 0;
    apply_reset();
    run_sb(2 * FRAME + 2, "full_frame", rd, f1, f2);
    checks++;
    if (rd !== HA * VA) begin
      failures++;
      $display("FAIL frame_reads got=%0d expected=%0d", rd, HA * VA);
    end
    checks++;
    if (f1 !== FRAME - 1 || f2 !== 2 * FRAME - 1) begin
      failures++;
      $display("FAIL frame_start_period got=%0d,%0d expected=%0d,%0d", f1, f2, FRAME - 1, 2 * FRAME - 1);
    end
  endtask

  // Line 0: hs low for HSW pixels starting the pixel after hcount = HS start,
  // blank_n low from the pixel after hcount = HA
  task automatic test_hsync();
    int hs_low, hs_first, bl_low, bl_first;
    pat_mode = 0;
    apply_reset();
    reset = 1'b0;
    hs_low = 0; hs_first = -1; bl_low = 0; bl_first = -1;
    for (int n = 0; n < HT * CD; n++) begin
      #1;
      if (!vga_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = n;
      end
      if (n >= CD && !vga_blank_n) begin
        bl_low++;
        if (bl_first < 0) bl_first = n;
      end
      @(negedge clk);
    end
    checks++;
    if (hs_low !== HSW * CD || hs_first !== (HA + HFP + 1) * CD) begin
      failures++;
      $display("FAIL hsync_window got len=%0d first=%0d expected len=%0d first=%0d",
               hs_low, hs_first, HSW * CD, (HA + HFP + 1) * CD);
    end
    checks++;
    if (bl_low !== (HT - 1 - HA) * CD || bl_first !== (HA + 1) * CD) begin
      failures++;
      $display("FAIL hblank_window got len=%0d first=%0d expected len=%0d first=%0d",
               bl_low, bl_first, (HT - 1 - HA) * CD, (HA + 1) * CD);
    end
  endtask

  task automatic test_vsync();
    int vs_low, vs_first, rd_late;
    pat_mode = 0;
    apply_reset();
    reset = 1'b0;
    vs_low = 0; vs_first = -1; rd_late = 0;
    for (int n = 0; n < FRAME; n++) begin
      #1;
      if (!vga_vs) begin
        vs_low++;
        if (vs_first < 0) vs_first = n;
      end
      if (n >= VA * HT * CD && fb_rd_en) rd_late++;
      @(negedge clk);
    end
    checks++;
    if (vs_low !== VSW * HT * CD || vs_first !== ((VA + VFP) * HT + 1) * CD) begin
      failures++;
      $display("FAIL vsync_window got len=%0d first=%0d expected len=%0d first=%0d",
               vs_low, vs_first, VSW * HT * CD, ((VA + VFP) * HT + 1) * CD);
    end
    checks++;
    if (rd_late !== 0) begin
      failures++;
      $display("FAIL vblank_reads got=%0d expected=0", rd_late);
    end
  endtask

  task automatic test_checkerboard();
    int rd, f1, f2;
    pat_mode = 1;
    apply_reset();
    run_sb(FRAME + 4, "checker", rd, f1, f2);
    checks++;
    if (rd !== HA * VA) begin
      failures++;
      $display("FAIL checker_reads got=%0d expected=%0d", rd, HA * VA);
    end
  endtask

  task automatic test_midline_reset();
    int rd, f1, f2;
    obs_t act;
    pat_mode = 1;
    apply_reset();
    // Clk 100 is div 0 of pixel (5, 3), inside the visible region
    run_sb(100, "pre_reset", rd, f1, f2);
    reset = 1'b1;
    #1;
    checks++;
    if ({fb_rd_en, fb_x, fb_y} !== {1'b0, 11'd5, 11'd3}) begin
      failures++;
      $display("FAIL reset_gates_read got rd=%b x=%0d y=%0d expected rd=0 x=5 y=3", fb_rd_en, fb_x, fb_y);
    end
    @(negedge clk); #1;
    act = sample();
    checks++;
    if (act !== reset_obs()) begin
      failures++;
      $display("FAIL midline_reset got=%h expected=%h", act, reset_obs());
    end
    @(negedge clk);
    run_sb(FRAME + 2, "post_reset", rd, f1, f2);
    checks++;
    if (f1 !== FRAME - 1) begin
      failures++;
      $display("FAIL post_reset_frame_start got=%0d expected=%0d", f1, FRAME - 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_first_read();
    test_full_frame();
    test_hsync();
    test_vsync();
    test_checkerboard();
    test_midline_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
